// File: rtl/zapper_flash_seq.sv
// zapper_flash_seq: light-gun flash sequencer that blanks, flashes target boxes and judges hits
module zapper_flash_seq #(
    parameter int NUM_TARGETS  = 2,
    parameter int COLOR_W      = 6,
    parameter int BOX_W        = 32,
    parameter int BOX_H        = 32,
    parameter int BLACK_FRAMES = 1,
    parameter int FLASH_FRAMES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid,
    input  logic [9:0]                col,
    input  logic [9:0]                row,
    input  logic                      frame_start,
    input  logic                      trigger,
    input  logic                      light,
    input  logic [COLOR_W-1:0]        scene_rgb,
    input  logic [NUM_TARGETS*10-1:0] target_x,
    input  logic [NUM_TARGETS*10-1:0] target_y,
    input  logic [NUM_TARGETS-1:0]    target_en,
    output logic [COLOR_W-1:0]        RGB,
    output logic                      hit,
    output logic [2:0]                hit_id,
    output logic                      miss,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, BLACK, FLASH, HELD} state_t;
    state_t      state;
    logic        trig_s1, trig_s2, trig_prev, light_s1, light_s2;
    logic [1:0]  fill;
    logic        armed, lit_flag;
    logic [2:0]  idx, first_idx, next_idx;
    logic        first_ok, next_ok;
    logic [3:0]  frame_cnt;
    logic [9:0]  box_x, box_y;
    logic        in_box, lit_now, lit_eff, trig_rise;

    assign in_box    = ({1'b0, col} >= {1'b0, box_x}) && ({1'b0, col} < {1'b0, box_x} + 11'(BOX_W)) &&
                       ({1'b0, row} >= {1'b0, box_y}) && ({1'b0, row} < {1'b0, box_y} + 11'(BOX_H));
    assign lit_now   = light_s2 && valid && (state == BLACK || (state == FLASH && in_box));
    assign lit_eff   = lit_flag || lit_now;
    assign trig_rise = trig_s2 && !trig_prev;
    assign busy      = (state == BLACK) || (state == FLASH);

    // Lowest enabled target, next enabled target above idx, and the box of the current target
    always_comb begin
        first_idx = '0;
        first_ok  = 1'b0;
        next_idx  = '0;
        next_ok   = 1'b0;
        box_x     = '0;
        box_y     = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (target_en[i]) begin
                first_idx = 3'(i);
                first_ok  = 1'b1;
            end
            if (target_en[i] && 3'(i) > idx) begin
                next_idx = 3'(i);
                next_ok  = 1'b1;
            end
            if (3'(i) == idx) begin
                box_x = target_x[10*i +: 10];
                box_y = target_y[10*i +: 10];
            end
        end
    end

    // Input synchronisers; the edge detector stays blind until the sync chain holds post-reset samples,
    // so a trigger held through reset cannot look like a fresh pull
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            light_s1  <= 1'b0;
            light_s2  <= 1'b0;
            fill      <= '0;
            trig_prev <= 1'b1;
        end else begin
            trig_s1   <= trigger;
            trig_s2   <= trig_s1;
            light_s1  <= light;
            light_s2  <= light_s1;
            fill      <= {fill[0], 1'b1};
            trig_prev <= fill[1] ? trig_s2 : 1'b1;
        end
    end

    // Frame-synchronous sequencer: arming, black/flash stepping, light judgement and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            lit_flag  <= 1'b0;
            idx       <= '0;
            frame_cnt <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            hit_id    <= '0;
        end else begin
            hit      <= 1'b0;
            miss     <= 1'b0;
            lit_flag <= frame_start ? 1'b0 : lit_eff;
            if (state == IDLE && !(frame_start && armed))
                armed <= armed || trig_rise;
            if (frame_start) begin
                case (state)
                    IDLE: if (armed) begin
                        state     <= BLACK;
                        armed     <= 1'b0;
                        frame_cnt <= 4'(BLACK_FRAMES - 1);
                    end
                    BLACK: if (frame_cnt != 4'd0) begin
                        frame_cnt <= frame_cnt - 4'd1;
                    end else if (lit_eff || !first_ok) begin
                        state <= HELD;
                        miss  <= 1'b1;
                    end else begin
                        state     <= FLASH;
                        idx       <= first_idx;
                        frame_cnt <= 4'(FLASH_FRAMES - 1);
                    end
                    FLASH: if (lit_eff) begin
                        hit    <= 1'b1;
                        hit_id <= idx;
                        state  <= HELD;
                    end else if (frame_cnt != 4'd0) begin
                        frame_cnt <= frame_cnt - 4'd1;
                    end else if (next_ok) begin
                        idx       <= next_idx;
                        frame_cnt <= 4'(FLASH_FRAMES - 1);
                    end else begin
                        state <= HELD;
                        miss  <= 1'b1;
                    end
                    HELD: if (!trig_s2) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output pixel: black outside the visible area and during BLACK, white box during FLASH, else scene
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) RGB <= '0;
        else        RGB <= (!valid || state == BLACK) ? '0 : (state == FLASH) ? {COLOR_W{in_box}} : scene_rgb;
    end
endmodule

// File: tb/tb_zapper_flash_seq.sv
// tb_zapper_flash_seq: randomized scoreboard bench for the light-gun flash sequencer
module tb_zapper_flash_seq;
    localparam int NT = 2, CW = 6, BW = 32, BH = 32, BF = 1, FF = 1;
    localparam int L = 303;

    logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, frame_start = 1'b0, trigger = 1'b0, light = 1'b0;
    logic [9:0] col = '0, row = '0;
    logic [CW-1:0] scene_rgb = '0;
    logic [NT*10-1:0] target_x = {10'd160, 10'd100};
    logic [NT*10-1:0] target_y = {10'd110, 10'd100};
    logic [NT-1:0] target_en = 2'b11;
    logic [CW-1:0] rgb;
    logic hit, miss, busy;
    logic [2:0] hit_id;

    always #5 clk = ~clk;

    zapper_flash_seq #(.NUM_TARGETS(NT), .COLOR_W(CW), .BOX_W(BW), .BOX_H(BH),
                       .BLACK_FRAMES(BF), .FLASH_FRAMES(FF)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .col(col), .row(row), .frame_start(frame_start),
        .trigger(trigger), .light(light), .scene_rgb(scene_rgb), .target_x(target_x),
        .target_y(target_y), .target_en(target_en), .RGB(rgb), .hit(hit), .hit_id(hit_id),
        .miss(miss), .busy(busy));

    typedef struct packed {
        logic [CW-1:0] rgb;
        logic hit;
        logic miss;
        logic busy;
        logic [2:0] hit_id;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int total = 0, bad = 0, cyc_n = 0;
    int dut_hits = 0, dut_misses = 0;

    // reference model: phase 0 idle, 1 black, 2 flash, 3 held; pend lists targets still to flash
    int ph = 0, left_m = 0, ecnt = 0;
    int pend[$];
    bit armed_m = 0, seen_m = 0, t1 = 0, t2 = 0, t3 = 0, l1 = 0, l2 = 0;
    logic [2:0] hid_m = '0;

    function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc_n, got, exp);
        end
    endfunction

    function automatic bit in_box(input int k, input int c, input int r);
        int x, y;
        x = int'(target_x[10*k +: 10]);
        y = int'(target_y[10*k +: 10]);
        return c >= x && c < x + BW && r >= y && r < y + BH;
    endfunction

    // monitor: one expected record per clock, compared away from the active edge
    always @(negedge clk) begin
        cyc_n++;
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("rgb", 32'(rgb), 32'(me.rgb));
            chk("hit", 32'(hit), 32'(me.hit));
            chk("miss", 32'(miss), 32'(me.miss));
            chk("busy", 32'(busy), 32'(me.busy));
            chk("hit_id", 32'(hit_id), 32'(me.hit_id));
            if (hit === 1'b1) dut_hits++;
            if (miss === 1'b1) dut_misses++;
        end
    end

    task automatic cyc(input bit v, input int c, input int r, input bit fs, input bit trg, input bit lt);
        exp_t e;
        bit ib, lit_now, rise, s;
        valid = v; col = 10'(c); row = 10'(r); frame_start = fs; trigger = trg; light = lt;
        scene_rgb = CW'($urandom);
        ib = 0;
        if (ph == 2) ib = in_box(pend[0], c, r);
        e = '0;
        e.rgb = (!v || ph == 1) ? '0 : (ph == 2) ? {CW{ib}} : scene_rgb;
        lit_now = l2 && v && (ph == 1 || ib);
        rise = ecnt >= 3 && t2 && !t3;
        s = seen_m || lit_now;
        seen_m = fs ? 1'b0 : s;
        if (ph == 0) begin
            if (fs && armed_m) begin ph = 1; armed_m = 0; left_m = BF; end
            else armed_m = armed_m || rise;
        end else if (fs) begin
            case (ph)
                1: begin
                    left_m--;
                    if (left_m == 0) begin
                        pend.delete();
                        for (int i = 0; i < NT; i++) if (target_en[i]) pend.push_back(i);
                        if (s || pend.size() == 0) begin e.miss = 1; ph = 3; end
                        else begin ph = 2; left_m = FF; end
                    end
                end
                2: if (s) begin
                    e.hit = 1; hid_m = 3'(pend[0]); ph = 3;
                end else begin
                    left_m--;
                    if (left_m == 0) begin
                        pend.delete(0);
                        if (pend.size() == 0) begin e.miss = 1; ph = 3; end
                        else left_m = FF;
                    end
                end
                default: if (!t2) ph = 0;
            endcase
        end
        e.busy = (ph == 1 || ph == 2);
        e.hit_id = hid_m;
        t3 = t2; t2 = t1; t1 = trg; l2 = l1; l1 = lt;
        ecnt++;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input bit trg);
        exp_t z;
        z = '0;
        rst_n = 0; trigger = trg; valid = 0; frame_start = 0; light = 0;
        ph = 0; armed_m = 0; seen_m = 0; left_m = 0; pend.delete(); hid_m = '0;
        t1 = 0; t2 = 0; t3 = 0; l1 = 0; l2 = 0; ecnt = 0;
        repeat (n) begin
            sb.push_back(z);
            @(negedge clk);
            #1;
        end
        rst_n = 1;
    endtask

    // one frame: 2 blank cycles, visible pixels, frame_start; light is driven 2 cycles ahead of the
    // pixel it describes so it meets that pixel at the synchroniser output
    task automatic frame(input int lmode, input int lk, input int on_at, input int off_at, input int len = L);
        int pc[L];
        int pr[L];
        bit pv[L];
        bit lt;
        for (int t = 0; t < L; t++) begin
            pv[t] = t >= 2 && t < L - 1 && ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) begin
                int k = int'($urandom_range(0, NT - 1));
                pc[t] = int'(target_x[10*k +: 10]) + int'($urandom_range(0, BW + 1)) - 1;
                pr[t] = int'(target_y[10*k +: 10]) + int'($urandom_range(0, BH + 1)) - 1;
            end else begin
                pc[t] = int'($urandom_range(0, 639));
                pr[t] = int'($urandom_range(0, 479));
            end
        end
        for (int t = 0; t < len; t++) begin
            case (lmode)
                1: lt = 1;
                2: lt = (t + 2 < L) && pv[t+2] && in_box(lk, pc[t+2], pr[t+2]);
                3: lt = ($urandom_range(0, 7) == 0);
                default: lt = 0;
            endcase
            cyc(pv[t], pc[t], pr[t], t == L - 1, t >= on_at && t < off_at, lt);
        end
    endtask

    task automatic arm();  frame(0, 0, 50, L); endtask
    task automatic hold(input int lmode, input int lk); frame(lmode, lk, 0, L); endtask
    task automatic rel();  frame(0, 0, 0, 10); endtask
    task automatic idle(); frame(0, 0, L, L); endtask

    initial begin
        int h0, m0;
        repeat (2) @(negedge clk);
        #1;
        do_reset(3, 0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rgb", 32'(rgb), 32'd0);
        idle();
        // hit on target 0, then trigger held for 3 frames, then release
        h0 = dut_hits; m0 = dut_misses;
        arm(); hold(0, 0); hold(2, 0);
        chk("s1_hits", 32'(dut_hits - h0), 32'd1);
        chk("s1_id", 32'(hit_id), 32'd0);
        hold(0, 0); hold(0, 0); hold(0, 0);
        chk("s1_held_busy", 32'(busy), 32'd0);
        rel(); idle();
        // light only on target 1's box: nothing after target 0's frame, hit on target 1
        h0 = dut_hits;
        arm(); hold(0, 0); hold(2, 1);
        chk("s2_no_early_hit", 32'(dut_hits - h0), 32'd0);
        hold(2, 1);
        chk("s2_hits", 32'(dut_hits - h0), 32'd1);
        chk("s2_id", 32'(hit_id), 32'd1);
        rel(); idle();
        // no light at all: miss after the last flash, hit_id kept
        m0 = dut_misses;
        arm(); hold(0, 0); hold(0, 0); hold(0, 0);
        chk("s3_miss", 32'(dut_misses - m0), 32'd1);
        chk("s3_id_kept", 32'(hit_id), 32'd1);
        rel(); idle();
        // lamp cheat: light during black frame
        h0 = dut_hits; m0 = dut_misses;
        arm(); hold(1, 0);
        chk("s4_miss", 32'(dut_misses - m0), 32'd1);
        chk("s4_nohit", 32'(dut_hits - h0), 32'd0);
        rel(); idle();
        // re-pull during black is ignored
        m0 = dut_misses;
        arm(); frame(0, 0, 150, L); hold(0, 0); hold(0, 0); rel(); idle(); idle();
        chk("s5_one_seq", 32'(dut_misses - m0), 32'd1);
        // enable gaps
        target_en = 2'b10;
        m0 = dut_misses;
        arm(); hold(0, 0); hold(0, 0);
        chk("s6_single_flash", 32'(dut_misses - m0), 32'd1);
        rel(); idle();
        target_en = 2'b00;
        m0 = dut_misses;
        arm(); hold(0, 0);
        chk("s7_none_enabled", 32'(dut_misses - m0), 32'd1);
        rel(); idle();
        target_en = 2'b11;
        // reset mid-flash with trigger held: no re-arm, then a fresh pull works
        h0 = dut_hits; m0 = dut_misses;
        arm(); hold(0, 0); frame(2, 0, 0, L, 150);
        do_reset(4, 1);
        chk("s8_busy", 32'(busy), 32'd0);
        hold(0, 0); hold(0, 0);
        chk("s8_no_pulse", 32'(dut_hits - h0 + dut_misses - m0), 32'd0);
        rel(); arm(); hold(0, 0); hold(2, 0);
        chk("s8_rearm_hit", 32'(dut_hits - h0), 32'd1);
        rel(); idle();
        // randomized frames
        for (int n = 0; n < 30; n++) begin
            int on, off;
            if (ph == 0) target_en = NT'($urandom);
            on = int'($urandom_range(0, L));
            off = int'($urandom_range(on, L));
            frame(int'($urandom_range(0, 3)), int'($urandom_range(0, NT - 1)), on, off);
        end
        repeat (2) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zapper_flash_seq.md
# zapper_flash_seq

Frame-synchronous light-gun flash sequencer for the Duck Hunt VGA pipeline. It sits between the scene ROM and the VGA output. On a trigger pull it blanks one or more frames to black, then flashes a white box over each enabled target in turn. It samples the gun photodiode to decide which target, if any, was hit. It generalises the single black/white flash to NUM_TARGETS targets, configurable frame counts, light sampling and hit/miss reporting.

## Interface
- NUM_TARGETS, 2: number of target boxes (1-8).
- COLOR_W, 6: pixel colour width (RRGGBB).
- BOX_W, 32: target box width in pixels.
- BOX_H, 32: target box height in pixels.
- BLACK_FRAMES, 1: black frames before the first flash (1-15).
- FLASH_FRAMES, 1: frames each target box is flashed (1-15).
- clk  in  1  pixel clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- valid  in  1  visible-area flag for the current col/row.
- col  in  10  current pixel column.
- row  in  10  current pixel row.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- trigger  in  1  raw gun trigger, asynchronous; 2-flop synchronised internally.
- light  in  1  raw gun photodiode, high means light seen; asynchronous; 2-flop synchronised internally.
- scene_rgb  in  COLOR_W  scene pixel from the ROM, aligned with col/row.
- target_x  in  NUM_TARGETS*10  top-left column per target; target i occupies bits [10i+9:10i].
- target_y  in  NUM_TARGETS*10  top-left row per target; same packing as target_x.
- target_en  in  NUM_TARGETS  target i is live and flashable.
- RGB  out  COLOR_W  registered output pixel.
- hit  out  1  one-cycle pulse: a target was hit.
- hit_id  out  3  index of the hit target; held until the next hit.
- miss  out  1  one-cycle pulse: the sequence ended with no hit.
- busy  out  1  high in BLACK and FLASH states.

## Operation
- States: IDLE, BLACK, FLASH, HELD.
- All state, target-index and frame-counter changes occur only on cycles where frame_start=1.
- Trigger arming:
  - A rising edge of synced trigger while in IDLE sets `armed`.
  - Rising edges in any other state are ignored.
- IDLE → BLACK on frame_start with armed=1. This clears armed and loads frame_cnt=BLACK_FRAMES-1.
- BLACK:
  - Each frame_start decrements frame_cnt.
  - When frame_cnt=0: if lit_flag=1 (light seen on a black frame), go to HELD and pulse miss. This is the lamp-cheat rejection.
  - Otherwise go to FLASH with idx = lowest enabled target and frame_cnt=FLASH_FRAMES-1.
  - If no target is enabled, go to HELD and pulse miss.
- FLASH:
  - On frame_start with lit_flag=1: pulse hit, set hit_id=idx, go to HELD. Remaining targets are skipped.
  - Else, when frame_cnt=0: advance idx to the next enabled target above idx. If there is none, pulse miss and go to HELD.
  - Else decrement frame_cnt.
- HELD → IDLE on frame_start when synced trigger=0.
- lit_flag:
  - Set when synced light=1 and valid=1 during a BLACK or FLASH frame.
  - In FLASH it is additionally gated by the beam being inside box idx.
  - Cleared on every frame_start, after being evaluated.
- Box membership: target_x ≤ col < target_x+BOX_W and target_y ≤ row < target_y+BOX_H. Compare at 11 bits so there is no wrap.
- Pixel output:
  - valid=0 gives 0.
  - BLACK gives 0.
  - FLASH gives all-ones inside box idx and 0 elsewhere.
  - IDLE and HELD give scene_rgb.
- target_en, target_x and target_y are sampled live; changes mid-sequence take effect at the next index advance.

## Timing
- RGB has 1-cycle latency from valid/col/row/scene_rgb.
- trigger and light have 2-cycle synchroniser latency. A light edge reaching the synchroniser output on the same cycle as frame_start counts toward the frame that is ending.
- hit and miss assert for exactly the clk cycle after the deciding frame_start.
- Minimum trigger-to-first-flash latency: the first frame_start after arming, plus BLACK_FRAMES frames.
- Reset values: state=IDLE, armed=0, lit_flag=0, idx=0, frame_cnt=0, RGB=0, hit=0, miss=0, hit_id=0, busy=0, synchroniser flops=0.
- rst_n asserted mid-sequence aborts immediately. No hit/miss pulse is emitted.
- A trigger held through reset does not arm. After reset a fresh rising edge is required.

## Test plan
- Hit on target 0: NUM_TARGETS=2, both enabled, target 0 at (100,100). Pull trigger; drive light only while the beam is in rows/cols 100-131 during the first FLASH frame. Expect: BLACK frame RGB=0; FLASH frame RGB=6'b111111 inside the box and 0 outside; hit pulse with hit_id=0 one cycle after the next frame_start; then HELD.
- Hit on second target: light is asserted only in target 1's box during its flash frame. Expect no pulse after target 0's frame, then hit with hit_id=1.
- Miss and cheat:
  - Light never asserted: miss pulses after the last FLASH frame, and hit_id is unchanged.
  - Light held high during the BLACK frame: miss pulses at the end of BLACK, and no FLASH frame occurs.
- Held trigger: keep trigger high after a hit for 3 frames. Expect state to stay HELD and RGB=scene_rgb. Release the trigger: expect IDLE at the next frame_start. A re-pull then starts a new sequence, while a re-pull during BLACK is ignored.
- Enable gaps: target_en=2'b10 gives a single flash on target 1; target_en=0 gives miss at the end of BLACK.
- Reset mid-FLASH: assert rst_n low. Expect RGB=0, busy=0, no pulses, state IDLE; a trigger still held high does not re-arm.
